wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 19 +
 rtl/wb_arbiter_scoreboard.sv | 53 +++++
 rtl/wb_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared defines for the writeback arbiter slice.
// Provides the register-file geometry (REG_WIDTH, REG_ADDR_WIDTH), the
// writeback source encoding (WB_SRC_ALU / WB_SRC_LSU) and the request struct
// that the arbiter muxes between its two channels.
package wb_arbiter_pkg;

  localparam int unsigned REG_WIDTH      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  // Writeback source encoding; also the value of the round-robin pointer.
  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_WIDTH-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_scoreboard.sv
// wb_scoreboard: per-register pending bits plus the two-port busy lookup.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   iss_valid, iss_rd     set pending bit iss_rd (ignored for x0)
//   clr_valid, clr_addr   clear pending bit clr_addr (the register-file write)
//   rs1_addr, rs2_addr    hazard query addresses
//   rs1_busy, rs2_busy    pending bit of the queried register, 0 for x0
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
  input  logic                      clr_valid,
  input  logic [REG_ADDR_WIDTH-1:0] clr_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  function automatic logic in_range(input logic [REG_ADDR_WIDTH-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // Clear first, then set, so a same-cycle issue to the written register wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_valid && in_range(clr_addr)) begin
      pend_d[clr_addr] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0) && in_range(iss_rd)) begin
      pend_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign rs1_busy = (rs1_addr != '0) && in_range(rs1_addr) && pend_q[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) && in_range(rs2_addr) && pend_q[rs2_addr];

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates ALU and load-unit writebacks onto one register-file
// write port and tracks outstanding destinations in a scoreboard.
// Configuration macro: WB_RR_ARB_EN selects round-robin arbitration; when it is
// undefined the LSU has fixed priority and no pointer flop exists.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   iss_valid, iss_rd                   mark an issued destination pending
//   alu_valid/rd/data, alu_ready        ALU writeback request channel
//   lsu_valid/rd/data, lsu_ready        load-unit writeback request channel
//   reg_wen, reg_w_addr, reg_w_data     registered register-file write port
//   rs1_addr, rs2_addr, rs1/rs2_busy    hazard query
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]      alu_data,
  output logic                      alu_ready,
  input  logic                      lsu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [REG_WIDTH-1:0]      lsu_data,
  output logic                      lsu_ready,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_w_addr,
  output logic [REG_WIDTH-1:0]      reg_w_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy
);

  logic    alu_grant, lsu_grant, any_grant;
  wb_req_t sel_req;

  logic                      wen_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [REG_WIDTH-1:0]      data_q;

`ifdef WB_RR_ARB_EN
  // Source that wins the next contested cycle.
  logic fav_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fav_q <= WB_SRC_LSU;
    end else if (alu_grant) begin
      fav_q <= WB_SRC_LSU;
    end else if (lsu_grant) begin
      fav_q <= WB_SRC_ALU;
    end
  end

  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (rst_n) begin
      if (alu_valid && lsu_valid) begin
        lsu_grant = (fav_q == WB_SRC_LSU);
        alu_grant = ~lsu_grant;
      end else begin
        alu_grant = alu_valid;
        lsu_grant = lsu_valid;
      end
    end
  end
`else
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (rst_n) begin
      lsu_grant = lsu_valid;
      alu_grant = alu_valid & ~lsu_valid;
    end
  end
`endif

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;
  assign any_grant = alu_grant | lsu_grant;

  always_comb begin
    sel_req = '{rd: alu_rd, data: alu_data};
    if (lsu_grant) begin
      sel_req = '{rd: lsu_rd, data: lsu_data};
    end
  end

  // Address/data follow every accepted request; the enable drops for x0 so the
  // handshake completes without a register-file write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q <= any_grant && (sel_req.rd != '0);
      if (any_grant) begin
        addr_q <= sel_req.rd;
        data_q <= sel_req.data;
      end
    end
  end

  assign reg_wen    = wen_q;
  assign reg_w_addr = addr_q;
  assign reg_w_data = data_q;

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .clr_valid (wen_q),
    .clr_addr  (addr_q),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

endmodule
